axi4_burst_master: RTL and testbench

//  AXI4 master stage that sits directly upstream of the memory-mapped AXI4 slave.

---
 rtl/axi4_pkg.sv | 26 ++
 rtl/axi4_burst_master.sv | 236 +++++++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_pkg.sv
// Shared types and helpers for the AXI4 burst master: response codes, FSM state, 4KB check.
package axi4_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StAw,
      StW,
      StB,
      StAr,
      StR,
      StDrain
   } mst_state_e;

   // Start address of the final beat must stay inside the same 4KB page.
   function automatic logic crosses_4k(input logic [11:0] addr,
                                       input logic [7:0]  len,
                                       input logic [2:0]  size);
      logic [12:0] w_last;
      w_last = {1'b0, addr} + (13'(len) << size);
      return w_last[12];
   endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst master: command in, AW/W/B or AR/R out, one completion
// pulse per command. Illegal commands are rejected locally without bus traffic.
module axi4_burst_master
   import axi4_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic [2:0]            cmd_size,
   input  logic                  wd_valid,
   output logic                  wd_ready,
   input  logic [DATA_WIDTH-1:0] wd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [1:0]            rd_resp,
   output logic                  rd_last,
   output logic                  done_valid,
   output logic [1:0]            done_resp,
   output logic [ADDR_WIDTH-1:0] AWADDR,
   output logic [7:0]            AWLEN,
   output logic [2:0]            AWSIZE,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [DATA_WIDTH-1:0] WDATA,
   output logic                  WLAST,
   output logic                  WVALID,
   input  logic                  WREADY,
   input  logic [1:0]            BRESP,
   input  logic                  BVALID,
   output logic                  BREADY,
   output logic [ADDR_WIDTH-1:0] ARADDR,
   output logic [7:0]            ARLEN,
   output logic [2:0]            ARSIZE,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   input  logic [DATA_WIDTH-1:0] RDATA,
   input  logic [1:0]            RRESP,
   input  logic                  RLAST,
   input  logic                  RVALID,
   output logic                  RREADY
);

   localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);

   mst_state_e            r_state,      w_state_d;
   logic                  r_cmd_ready,  w_cmd_ready_d;
   logic                  r_awvalid,    w_awvalid_d;
   logic                  r_arvalid,    w_arvalid_d;
   logic                  r_bready,     w_bready_d;
   logic                  r_done_valid, w_done_valid_d;
   logic [1:0]            r_done_resp,  w_done_resp_d;
   logic [ADDR_WIDTH-1:0] r_addr,       w_addr_d;
   logic [7:0]            r_len,        w_len_d;
   logic [2:0]            r_size,       w_size_d;
   logic [7:0]            r_beat_cnt,   w_beat_cnt_d;
   logic [1:0]            r_worst_resp, w_worst_resp_d;
   logic                  r_rd_err,     w_rd_err_d;
   logic                  w_illegal;
   logic [1:0]            w_resp_max;

   assign w_illegal  = (cmd_size > 3'(MAX_SIZE)) || crosses_4k(cmd_addr[11:0], cmd_len, cmd_size);
   assign w_resp_max = (RRESP > r_worst_resp) ? RRESP : r_worst_resp;

   always_comb begin
      w_state_d      = r_state;
      w_cmd_ready_d  = r_cmd_ready;
      w_awvalid_d    = r_awvalid;
      w_arvalid_d    = r_arvalid;
      w_bready_d     = r_bready;
      w_done_valid_d = 1'b0;
      w_done_resp_d  = r_done_resp;
      w_addr_d       = r_addr;
      w_len_d        = r_len;
      w_size_d       = r_size;
      w_beat_cnt_d   = r_beat_cnt;
      w_worst_resp_d = r_worst_resp;
      w_rd_err_d     = r_rd_err;
      wd_ready       = 1'b0;
      WVALID         = 1'b0;
      WDATA          = '0;
      WLAST          = 1'b0;
      rd_valid       = 1'b0;
      rd_data        = '0;
      rd_resp        = '0;
      rd_last        = 1'b0;
      RREADY         = 1'b0;

      case (r_state)
         StIdle: begin
            w_cmd_ready_d = 1'b1;
            if (cmd_valid && r_cmd_ready) begin
               w_cmd_ready_d  = 1'b0;
               w_addr_d       = cmd_addr;
               w_len_d        = cmd_len;
               w_size_d       = cmd_size;
               w_beat_cnt_d   = '0;
               w_worst_resp_d = RESP_OKAY;
               w_rd_err_d     = 1'b0;
               if (w_illegal) begin
                  // Rejected writes still have to swallow their data beats.
                  if (cmd_write) begin
                     w_state_d = StDrain;
                  end else begin
                     w_done_valid_d = 1'b1;
                     w_done_resp_d  = RESP_SLVERR;
                  end
               end else if (cmd_write) begin
                  w_state_d   = StAw;
                  w_awvalid_d = 1'b1;
               end else begin
                  w_state_d   = StAr;
                  w_arvalid_d = 1'b1;
               end
            end
         end
         StAw: begin
            if (AWREADY) begin
               w_awvalid_d = 1'b0;
               w_state_d   = StW;
            end
         end
         StW: begin
            WVALID   = wd_valid;
            WDATA    = wd_data;
            wd_ready = WREADY;
            WLAST    = (r_beat_cnt == r_len);
            if (wd_valid && WREADY) begin
               w_beat_cnt_d = r_beat_cnt + 8'd1;
               if (r_beat_cnt == r_len) begin
                  w_state_d  = StB;
                  w_bready_d = 1'b1;
               end
            end
         end
         StB: begin
            if (BVALID) begin
               w_bready_d     = 1'b0;
               w_done_valid_d = 1'b1;
               w_done_resp_d  = BRESP;
               w_state_d      = StIdle;
            end
         end
         StAr: begin
            if (ARREADY) begin
               w_arvalid_d = 1'b0;
               w_state_d   = StR;
            end
         end
         StR: begin
            rd_valid = RVALID;
            rd_data  = RDATA;
            rd_resp  = RRESP;
            rd_last  = RLAST;
            RREADY   = rd_ready;
            if (RVALID && rd_ready) begin
               w_beat_cnt_d   = r_beat_cnt + 8'd1;
               w_worst_resp_d = w_resp_max;
               if (RLAST) begin
                  w_done_valid_d = 1'b1;
                  w_done_resp_d  = (r_rd_err || (r_beat_cnt != r_len)) ? RESP_SLVERR : w_resp_max;
                  w_state_d      = StIdle;
               end else if (r_beat_cnt == r_len) begin
                  // Expected final beat arrived without RLAST; anything further is overrun.
                  w_rd_err_d = 1'b1;
               end
            end
         end
         StDrain: begin
            wd_ready = 1'b1;
            if (wd_valid) begin
               w_beat_cnt_d = r_beat_cnt + 8'd1;
               if (r_beat_cnt == r_len) begin
                  w_done_valid_d = 1'b1;
                  w_done_resp_d  = RESP_SLVERR;
                  w_state_d      = StIdle;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state      <= StIdle;
         r_cmd_ready  <= 1'b0;
         r_awvalid    <= 1'b0;
         r_arvalid    <= 1'b0;
         r_bready     <= 1'b0;
         r_done_valid <= 1'b0;
         r_done_resp  <= '0;
         r_addr       <= '0;
         r_len        <= '0;
         r_size       <= '0;
         r_beat_cnt   <= '0;
         r_worst_resp <= '0;
         r_rd_err     <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_cmd_ready  <= w_cmd_ready_d;
         r_awvalid    <= w_awvalid_d;
         r_arvalid    <= w_arvalid_d;
         r_bready     <= w_bready_d;
         r_done_valid <= w_done_valid_d;
         r_done_resp  <= w_done_resp_d;
         r_addr       <= w_addr_d;
         r_len        <= w_len_d;
         r_size       <= w_size_d;
         r_beat_cnt   <= w_beat_cnt_d;
         r_worst_resp <= w_worst_resp_d;
         r_rd_err     <= w_rd_err_d;
      end
   end

   assign cmd_ready  = r_cmd_ready;
   assign done_valid = r_done_valid;
   assign done_resp  = r_done_resp;
   assign AWADDR     = r_addr;
   assign AWLEN      = r_len;
   assign AWSIZE     = r_size;
   assign AWVALID    = r_awvalid;
   assign ARADDR     = r_addr;
   assign ARLEN      = r_len;
   assign ARSIZE     = r_size;
   assign ARVALID    = r_arvalid;
   assign BREADY     = r_bready;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: bench-driven slave, hand-computed expectations.
module tb_axi4_burst_master;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [15:0] cmd_addr = '0;
   logic [7:0]  cmd_len = '0;
   logic [2:0]  cmd_size = '0;
   logic        wd_valid = 1'b0, wd_ready;
   logic [31:0] wd_data = '0;
   logic        rd_valid, rd_ready = 1'b0, rd_last;
   logic [31:0] rd_data;
   logic [1:0]  rd_resp;
   logic        done_valid;
   logic [1:0]  done_resp;
   logic [15:0] AWADDR, ARADDR;
   logic [7:0]  AWLEN, ARLEN;
   logic [2:0]  AWSIZE, ARSIZE;
   logic        AWVALID, AWREADY = 1'b0;
   logic [31:0] WDATA;
   logic        WLAST, WVALID, WREADY = 1'b0;
   logic [1:0]  BRESP = '0;
   logic        BVALID = 1'b0, BREADY;
   logic        ARVALID, ARREADY = 1'b0;
   logic [31:0] RDATA = '0;
   logic [1:0]  RRESP = '0;
   logic        RLAST = 1'b0, RVALID = 1'b0, RREADY;

   int unsigned n_vec = 0;
   int unsigned n_miscmp = 0;
   logic [31:0] mem [16];

   axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .rd_resp(rd_resp), .rd_last(rd_last),
      .done_valid(done_valid), .done_resp(done_resp),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size);
      check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_size  = size;
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          beats;
      logic        hs;
      logic        seen;
      logic [1:0]  resp4 [3];
      resp4 = '{2'b00, 2'b10, 2'b00};

      // Reset state
      #2;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_awvalid", 32'(AWVALID), 32'd0);
      check("rst_arvalid", 32'(ARVALID), 32'd0);
      check("rst_done", {29'd0, done_valid, done_resp}, 32'd0);
      check("rst_awaddr", 32'(AWADDR), 32'd0);
      #10 ARESETn = 1'b1;
      step();

      // 1: write 0x10, len 3, data 1..4, AWREADY delayed
      send_cmd(1'b1, 16'h0010, 8'd3, 3'd2);
      check("t1_cmd_ready_low", 32'(cmd_ready), 32'd0);
      check("t1_awvalid", 32'(AWVALID), 32'd1);
      check("t1_awaddr", 32'(AWADDR), 32'h10);
      check("t1_awlen", 32'(AWLEN), 32'd3);
      check("t1_awsize", 32'(AWSIZE), 32'd2);
      step();
      step();
      check("t1_aw_hold_valid", 32'(AWVALID), 32'd1);
      check("t1_aw_hold_addr", 32'(AWADDR), 32'h10);
      AWREADY = 1'b1;
      step();
      AWREADY = 1'b0;
      check("t1_awvalid_drop", 32'(AWVALID), 32'd0);
      for (int i = 0; i < 4; i++) begin
         wd_valid = 1'b1;
         wd_data  = 32'(i + 1);
         WREADY   = 1'b1;
         #1;
         check("t1_wvalid", 32'(WVALID), 32'd1);
         check("t1_wdata", WDATA, 32'(i + 1));
         check("t1_wlast", 32'(WLAST), (i == 3) ? 32'd1 : 32'd0);
         mem[4 + i] = WDATA;
         step();
      end
      wd_valid = 1'b0;
      WREADY   = 1'b0;
      check("t1_bready", 32'(BREADY), 32'd1);
      BVALID = 1'b1;
      BRESP  = 2'b00;
      step();
      BVALID = 1'b0;
      check("t1_done", {29'd0, done_valid, done_resp}, 32'b100);
      check("t1_bready_drop", 32'(BREADY), 32'd0);
      check("t1_no_accept_in_done", 32'(cmd_ready), 32'd0);
      step();
      check("t1_done_pulse", 32'(done_valid), 32'd0);

      // 2: read back 0x10, len 3
      send_cmd(1'b0, 16'h0010, 8'd3, 3'd2);
      check("t2_arvalid", 32'(ARVALID), 32'd1);
      check("t2_araddr", 32'(ARADDR), 32'h10);
      check("t2_arlen", 32'(ARLEN), 32'd3);
      ARREADY = 1'b1;
      step();
      ARREADY = 1'b0;
      check("t2_arvalid_drop", 32'(ARVALID), 32'd0);
      for (int i = 0; i < 4; i++) begin
         RVALID   = 1'b1;
         RDATA    = mem[4 + i];
         RRESP    = 2'b00;
         RLAST    = (i == 3);
         rd_ready = 1'b1;
         #1;
         check("t2_rd_data", rd_data, 32'(i + 1));
         check("t2_rd_last", 32'(rd_last), (i == 3) ? 32'd1 : 32'd0);
         check("t2_rready", 32'(RREADY), 32'd1);
         step();
         if (i < 3) check("t2_no_early_done", 32'(done_valid), 32'd0);
      end
      RVALID   = 1'b0;
      RLAST    = 1'b0;
      rd_ready = 1'b0;
      check("t2_done", {29'd0, done_valid, done_resp}, 32'b100);
      step();

      // 3: write crossing 4KB is drained locally
      send_cmd(1'b1, 16'h0FF8, 8'd3, 3'd2);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wd_valid = 1'b1;
         wd_data  = 32'hD0 + 32'(i);
         #1;
         check("t3_wd_ready", 32'(wd_ready), 32'd1);
         seen = seen | AWVALID | WVALID | ARVALID;
         step();
      end
      wd_valid = 1'b0;
      check("t3_no_bus", 32'(seen | AWVALID), 32'd0);
      check("t3_done", {29'd0, done_valid, done_resp}, 32'b110);
      step();

      // Oversized SIZE on a read: immediate error completion
      send_cmd(1'b0, 16'h0000, 8'd0, 3'd3);
      check("tsz_arvalid", 32'(ARVALID), 32'd0);
      check("tsz_done", {29'd0, done_valid, done_resp}, 32'b110);
      step();

      // 4: read len 2, RRESP 00/10/00, rd_ready toggling
      send_cmd(1'b0, 16'h0020, 8'd2, 3'd2);
      ARREADY = 1'b1;
      step();
      ARREADY = 1'b0;
      beats = 0;
      for (int cyc = 0; cyc < 20 && beats < 3; cyc++) begin
         rd_ready = (cyc % 2 == 1);
         RVALID   = 1'b1;
         RDATA    = 32'hA0 + 32'(beats);
         RRESP    = resp4[beats];
         RLAST    = (beats == 2);
         #1;
         hs = RVALID && RREADY;
         if (hs) check("t4_rd_data", rd_data, 32'hA0 + 32'(beats));
         step();
         if (hs) beats++;
      end
      RVALID   = 1'b0;
      RLAST    = 1'b0;
      rd_ready = 1'b0;
      check("t4_beats", 32'(beats), 32'd3);
      check("t4_done", {29'd0, done_valid, done_resp}, 32'b110);
      step();

      // 5: early RLAST on beat 2 of a len=3 read
      send_cmd(1'b0, 16'h0030, 8'd3, 3'd2);
      ARREADY = 1'b1;
      step();
      ARREADY = 1'b0;
      for (int i = 0; i < 2; i++) begin
         RVALID   = 1'b1;
         RDATA    = 32'(i);
         RRESP    = 2'b00;
         RLAST    = (i == 1);
         rd_ready = 1'b1;
         step();
      end
      RVALID   = 1'b0;
      RLAST    = 1'b0;
      rd_ready = 1'b0;
      check("t5_done", {29'd0, done_valid, done_resp}, 32'b110);
      step();

      // 6: reset during W beat 2, then a len=0 write
      send_cmd(1'b1, 16'h0040, 8'd3, 3'd2);
      AWREADY = 1'b1;
      step();
      AWREADY  = 1'b0;
      wd_valid = 1'b1;
      WREADY   = 1'b1;
      wd_data  = 32'h11;
      step();
      wd_data = 32'h12;
      #1;
      check("t6_wvalid_pre", 32'(WVALID), 32'd1);
      ARESETn = 1'b0;
      #1;
      check("t6_wvalid_rst", 32'(WVALID), 32'd0);
      check("t6_bready_rst", 32'(BREADY), 32'd0);
      check("t6_done_rst", 32'(done_valid), 32'd0);
      check("t6_cmd_ready_rst", 32'(cmd_ready), 32'd0);
      wd_valid = 1'b0;
      WREADY   = 1'b0;
      #2 ARESETn = 1'b1;
      step();
      send_cmd(1'b1, 16'h0050, 8'd0, 3'd2);
      check("t6_awvalid", 32'(AWVALID), 32'd1);
      check("t6_awlen", 32'(AWLEN), 32'd0);
      AWREADY = 1'b1;
      step();
      AWREADY  = 1'b0;
      wd_valid = 1'b1;
      WREADY   = 1'b1;
      wd_data  = 32'h55;
      #1;
      check("t6_wlast_first", 32'(WLAST), 32'd1);
      step();
      wd_valid = 1'b0;
      WREADY   = 1'b0;
      check("t6_bready", 32'(BREADY), 32'd1);
      BVALID = 1'b1;
      BRESP  = 2'b00;
      step();
      BVALID = 1'b0;
      check("t6_done", {29'd0, done_valid, done_resp}, 32'b100);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
